// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target: FSM states, bus bit constants and address decode helper.
// The controller side of the bus imports the same package so both agree on ACK polarity and R/W position.
package i2c_target_regs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic       ACK       = 1'b0;
    localparam logic       NACK      = 1'b1;
    localparam logic       RW_WRITE  = 1'b0;
    localparam int         RW_BIT    = 0;
    localparam int         CNT_W     = 4;
    localparam logic [3:0] BYTE_BITS = 4'd8;

    // Address frame is {addr[6:0], rw}; only the upper seven bits select the target.
    function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] addr);
        return frame[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_target_regs_line_sync.sv
// Brings raw SCL/SDA into the system clock domain and flags SCL edges plus START/STOP conditions.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges when reset releases.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], i_scl};
        sda_sync_d = {sda_sync_q[0], i_sda};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign o_scl       = scl_sync_q[1];
    assign o_sda       = sda_sync_q[1];
    assign o_scl_rise  =  scl_sync_q[1] & ~scl_prev_q;
    assign o_scl_fall  = ~scl_sync_q[1] &  scl_prev_q;
    // SCL must be high on both samples so an SCL edge coinciding with SDA is not mistaken for a condition.
    assign o_start_det =  scl_sync_q[1] & scl_prev_q &  sda_prev_q & ~sda_sync_q[1];
    assign o_stop_det  =  scl_sync_q[1] & scl_prev_q & ~sda_prev_q &  sda_sync_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping 7-bit addressed transfers onto a byte register port with an auto-increment pointer.
// SDA is open-drain (only the enable toggles) and SCL is never stretched.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         DATA_DEPTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    output logic                  o_sda,
    output logic                  o_wr_valid,
    output logic [DATA_DEPTH-1:0] o_wr_addr,
    output logic [DATA_DEPTH-1:0] o_wr_data,
    output logic [DATA_DEPTH-1:0] o_rd_addr,
    input  logic [DATA_DEPTH-1:0] i_rd_data,
    output logic                  o_busy
);

    logic line_scl, line_sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scl       (i_scl),
        .i_sda       (i_sda),
        .o_scl       (line_scl),
        .o_sda       (line_sda),
        .o_scl_rise  (scl_rise),
        .o_scl_fall  (scl_fall),
        .o_start_det (start_det),
        .o_stop_det  (stop_det)
    );

    state_t                state_q, state_d;
    logic [DATA_DEPTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_DEPTH-1:0] pointer_q, pointer_d;
    logic                  first_byte_q, first_byte_d;
    logic                  rw_q, rw_d;
    logic                  nack_q, nack_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [DATA_DEPTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_DEPTH-1:0] wr_data_q, wr_data_d;

    logic bit_close;
    logic byte_done;

    // SDA may only move while SCL is low, so every drive change is keyed to a qualified falling edge.
    assign bit_close = scl_fall & ~line_scl;
    assign byte_done = bit_close & (bit_cnt_q == BYTE_BITS);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pointer_d    = pointer_q;
        first_byte_d = first_byte_q;
        rw_d         = rw_q;
        nack_d       = nack_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATA_DEPTH-2:0], line_sda};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (byte_done) begin
                        rw_d = shift_q[RW_BIT];
                        if (addr_match(shift_q, TARGET_ADDR)) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (bit_close) begin
                        bit_cnt_d = '0;
                        if (rw_q == RW_WRITE) begin
                            state_d      = ST_WR_BYTE;
                            first_byte_d = 1'b1;
                            sda_oe_d     = 1'b0;
                        end else begin
                            state_d   = ST_RD_BYTE;
                            shift_d   = i_rd_data;
                            pointer_d = pointer_q + DATA_DEPTH'(1);
                            sda_oe_d  = ~i_rd_data[DATA_DEPTH-1];
                        end
                    end
                end

                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATA_DEPTH-2:0], line_sda};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (byte_done) begin
                        state_d  = ST_WR_ACK;
                        sda_oe_d = 1'b1;
                        // The first data byte after the address selects the register; later bytes are writes.
                        if (first_byte_q) begin
                            pointer_d    = shift_q;
                            first_byte_d = 1'b0;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = pointer_q;
                            wr_data_d  = shift_q;
                            pointer_d  = pointer_q + DATA_DEPTH'(1);
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (bit_close) begin
                        state_d   = ST_WR_BYTE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end

                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (byte_done) begin
                        state_d  = ST_RD_ACK;
                        sda_oe_d = 1'b0;
                    end else if (bit_close) begin
                        shift_d  = {shift_q[DATA_DEPTH-2:0], 1'b0};
                        sda_oe_d = ~shift_q[DATA_DEPTH-2];
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = line_sda;
                    end else if (bit_close) begin
                        if (nack_q == ACK) begin
                            state_d   = ST_RD_BYTE;
                            bit_cnt_d = '0;
                            shift_d   = i_rd_data;
                            pointer_d = pointer_q + DATA_DEPTH'(1);
                            sda_oe_d  = ~i_rd_data[DATA_DEPTH-1];
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pointer_q    <= '0;
            first_byte_q <= 1'b0;
            rw_q         <= RW_WRITE;
            nack_q       <= NACK;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pointer_q    <= pointer_d;
            first_byte_q <= first_byte_d;
            rw_q         <= rw_d;
            nack_q       <= nack_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign o_sda_oe   = sda_oe_q;
    assign o_sda      = 1'b0;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_addr  = pointer_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-level bus controller drives transfers while scoreboards
// hold the register writes and read bytes the target is expected to produce.
module tb_i2c_target_regs;

    logic       clk;
    logic       rst;
    logic       sclDrv;
    logic       sdaDrv;
    logic       sdaLine;
    logic       oSdaOe;
    logic       oSda;
    logic       oWrValid;
    logic [7:0] oWrAddr;
    logic [7:0] oWrData;
    logic [7:0] oRdAddr;
    logic [7:0] iRdData;
    logic       oBusy;

    int testCount = 0;
    int failCount = 0;
    int wrCount   = 0;
    bit oeSeen    = 1'b0;
    bit busySeen  = 1'b0;

    logic [15:0] wrQ[$];
    logic [7:0]  rdQ[$];

    i2c_target_regs #(.TARGET_ADDR(7'h42), .DATA_DEPTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (sclDrv),
        .i_sda      (sdaLine),
        .o_sda_oe   (oSdaOe),
        .o_sda      (oSda),
        .o_wr_valid (oWrValid),
        .o_wr_addr  (oWrAddr),
        .o_wr_data  (oWrData),
        .o_rd_addr  (oRdAddr),
        .i_rd_data  (iRdData),
        .o_busy     (oBusy)
    );

    // Wired-AND bus: the target can only pull the line low.
    assign sdaLine = sdaDrv & (oSdaOe ? oSda : 1'b1);
    assign iRdData = ~oRdAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (oSdaOe) oeSeen = 1'b1;
        if (oBusy) busySeen = 1'b1;
        if (!rst && oWrValid) begin
            wrCount++;
            testCount++;
            assert (wrQ.size() > 0) else begin
                failCount++;
                $error("[TB] FAIL wr_unexpected: observed addr %h data %h required no write", oWrAddr, oWrData);
            end
            if (wrQ.size() > 0) checkOutput("wr_pulse", {oWrAddr, oWrData}, wrQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic scl, input logic sda, input int clks);
        sclDrv = scl;
        sdaDrv = sda;
        repeat (clks) @(negedge clk);
    endtask

    // One SCL period of 20 system clocks; the line is sampled in the middle of the high phase.
    task automatic sendBit(input logic b, output logic s);
        applyStimulus(1'b0, b, 5);
        applyStimulus(1'b1, b, 5);
        s = sdaLine;
        applyStimulus(1'b1, b, 5);
        applyStimulus(1'b0, b, 5);
    endtask

    task automatic busStart();
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 5);
    endtask

    task automatic busStop();
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 10);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sendBit(b[i], s);
        sendBit(1'b1, ack);
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] data);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, s);
            data[i] = s;
        end
        sendBit(ackBit, s);
    endtask

    task automatic clearFlags();
        oeSeen   = 1'b0;
        busySeen = 1'b0;
        wrCount  = 0;
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;

        rst    = 1'b1;
        sclDrv = 1'b1;
        sdaDrv = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_sda_oe", 16'(oSdaOe), 16'h0);
        checkOutput("rst_sda", 16'(oSda), 16'h0);
        checkOutput("rst_wr_valid", 16'(oWrValid), 16'h0);
        checkOutput("rst_wr_addr_data", {oWrAddr, oWrData}, 16'h0000);
        checkOutput("rst_rd_addr", 16'(oRdAddr), 16'h0);
        checkOutput("rst_busy", 16'(oBusy), 16'h0);

        // Write with auto-increment
        clearFlags();
        wrQ.push_back(16'h10AB);
        wrQ.push_back(16'h11CD);
        busStart();
        sendByte(8'h84, ack); checkOutput("t1_addr_ack", 16'(ack), 16'h0);
        checkOutput("t1_busy", 16'(oBusy), 16'h1);
        sendByte(8'h10, ack); checkOutput("t1_ptr_ack", 16'(ack), 16'h0);
        sendByte(8'hAB, ack); checkOutput("t1_d0_ack", 16'(ack), 16'h0);
        sendByte(8'hCD, ack); checkOutput("t1_d1_ack", 16'(ack), 16'h0);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t1_pointer", 16'(oRdAddr), 16'h12);
        checkOutput("t1_busy_after_stop", 16'(oBusy), 16'h0);
        checkOutput("t1_wr_count", 16'(wrCount), 16'd2);

        // Read after setting the pointer, using a repeated START
        clearFlags();
        busStart();
        sendByte(8'h84, ack); checkOutput("t2_addr_ack", 16'(ack), 16'h0);
        sendByte(8'h05, ack); checkOutput("t2_ptr_ack", 16'(ack), 16'h0);
        busStart();
        sendByte(8'h85, ack); checkOutput("t2_raddr_ack", 16'(ack), 16'h0);
        rdQ.push_back(8'hFA);
        rdQ.push_back(8'hF9);
        readByte(1'b0, rd); checkOutput("t2_rd0", 16'(rd), 16'(rdQ.pop_front()));
        readByte(1'b1, rd); checkOutput("t2_rd1", 16'(rd), 16'(rdQ.pop_front()));
        repeat (3) @(negedge clk);
        checkOutput("t2_sda_released", 16'(oSdaOe), 16'h0);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t2_wr_count", 16'(wrCount), 16'd0);
        checkOutput("t2_pointer", 16'(oRdAddr), 16'h07);

        // Foreign address is ignored
        clearFlags();
        busStart();
        sendByte(8'h90, ack); checkOutput("t3_addr_nack", 16'(ack), 16'h1);
        sendByte(8'h11, ack); checkOutput("t3_data_nack", 16'(ack), 16'h1);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t3_oe_seen", 16'(oeSeen), 16'h0);
        checkOutput("t3_busy_seen", 16'(busySeen), 16'h0);
        checkOutput("t3_wr_count", 16'(wrCount), 16'd0);

        // Pointer wrap
        clearFlags();
        wrQ.push_back(16'hFF01);
        wrQ.push_back(16'h0002);
        busStart();
        sendByte(8'h84, ack); checkOutput("t4_addr_ack", 16'(ack), 16'h0);
        sendByte(8'hFF, ack); checkOutput("t4_ptr_ack", 16'(ack), 16'h0);
        sendByte(8'h01, ack); checkOutput("t4_d0_ack", 16'(ack), 16'h0);
        sendByte(8'h02, ack); checkOutput("t4_d1_ack", 16'(ack), 16'h0);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t4_wr_count", 16'(wrCount), 16'd2);
        checkOutput("t4_pointer", 16'(oRdAddr), 16'h01);

        // STOP in the middle of a data byte, then a normal write
        clearFlags();
        busStart();
        sendByte(8'h84, ack); checkOutput("t5_addr_ack", 16'(ack), 16'h0);
        sendByte(8'h20, ack); checkOutput("t5_ptr_ack", 16'(ack), 16'h0);
        sendBit(1'b1, s);
        sendBit(1'b0, s);
        sendBit(1'b1, s);
        sendBit(1'b0, s);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t5_partial_wr_count", 16'(wrCount), 16'd0);
        checkOutput("t5_partial_busy", 16'(oBusy), 16'h0);
        wrQ.push_back(16'h305A);
        busStart();
        sendByte(8'h84, ack); checkOutput("t5_new_addr_ack", 16'(ack), 16'h0);
        sendByte(8'h30, ack); checkOutput("t5_new_ptr_ack", 16'(ack), 16'h0);
        sendByte(8'h5A, ack); checkOutput("t5_new_d_ack", 16'(ack), 16'h0);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t5_wr_count", 16'(wrCount), 16'd1);
        checkOutput("t5_pointer", 16'(oRdAddr), 16'h31);

        // Asynchronous reset while the target drives a 0 data bit
        clearFlags();
        busStart();
        sendByte(8'h84, ack); checkOutput("t6_addr_ack", 16'(ack), 16'h0);
        sendByte(8'h40, ack); checkOutput("t6_ptr_ack", 16'(ack), 16'h0);
        busStart();
        sendByte(8'h85, ack); checkOutput("t6_raddr_ack", 16'(ack), 16'h0);
        sendBit(1'b1, s);     checkOutput("t6_rd_bit7", 16'(s), 16'h1);
        checkOutput("t6_driving_zero", 16'(oSdaOe), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_release", 16'(oSdaOe), 16'h0);
        checkOutput("t6_rst_wr_valid", 16'(oWrValid), 16'h0);
        checkOutput("t6_rst_wr_addr_data", {oWrAddr, oWrData}, 16'h0000);
        checkOutput("t6_rst_rd_addr", 16'(oRdAddr), 16'h0);
        checkOutput("t6_rst_busy", 16'(oBusy), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 10);
        wrQ.push_back(16'h0799);
        busStart();
        sendByte(8'h84, ack); checkOutput("t6_post_addr_ack", 16'(ack), 16'h0);
        sendByte(8'h07, ack); checkOutput("t6_post_ptr_ack", 16'(ack), 16'h0);
        sendByte(8'h99, ack); checkOutput("t6_post_d_ack", 16'(ack), 16'h0);
        busStop();
        repeat (5) @(negedge clk);
        checkOutput("t6_post_wr_count", 16'(wrCount), 16'd1);
        checkOutput("t6_post_pointer", 16'(oRdAddr), 16'h08);

        checkOutput("wr_queue_drained", 16'(wrQ.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
